// File: rtl/skip_pkg.sv
// Shared constants, FSM state encoding and table-entry layout for the skip-ring scheduler.
package skip_pkg;

   localparam int LEN_DEF   = 16;
   localparam int DEPTH_DEF = 4;
   localparam int REPW_DEF  = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

   // Entry layout at the default widths; modules build the same {mask, rep} shape from their parameters.
   typedef struct packed {
      logic [LEN_DEF-1:0]  mask;
      logic [REPW_DEF-1:0] rep;
   } entry_t;

endpackage

// File: rtl/skip_masktab.sv
// Mask/revolution table: one write port, one asynchronous read port, cleared by reset.
module skip_masktab
   import skip_pkg::*;
#(
   parameter int LEN   = LEN_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int REPW  = REPW_DEF,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic            iCLK,
   input  logic            nRST,
   input  logic            WE,
   input  logic [AW-1:0]   WADDR,
   input  logic [LEN-1:0]  WMASK,
   input  logic [REPW-1:0] WREP,
   input  logic [AW-1:0]   RADDR,
   output logic [LEN-1:0]  RMASK,
   output logic [REPW-1:0] RREP
);

   typedef struct packed {
      logic [LEN-1:0]  mask;
      logic [REPW-1:0] rep;
   } tab_entry_t;

   tab_entry_t             tab_reg [DEPTH];
   logic       [DEPTH-1:0] we_vec;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_we
         assign we_vec[gi] = WE && (WADDR == AW'(gi));
      end
   endgenerate

   always_ff @(posedge iCLK) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (!nRST)
            tab_reg[i] <= '0;
         else if (we_vec[i])
            tab_reg[i] <= '{mask: WMASK, rep: WREP};
      end
   end

   assign RMASK = tab_reg[RADDR].mask;
   assign RREP  = tab_reg[RADDR].rep;

endmodule

// File: rtl/skip_sched.sv
// Skip-ring mask sequencer: steps through table entries, holding each mask for its revolution count.
// Optional SKIP_SCHED_LOOP_EN: wrap to entry 0 at end of sequence instead of finishing.
module skip_sched
   import skip_pkg::*;
#(
   parameter int LEN   = LEN_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int REPW  = REPW_DEF
) (
   input  logic                     iCLK,
   input  logic                     nRST,
   input  logic                     START,
   input  logic                     STOP,
   input  logic                     WE,
   input  logic [$clog2(DEPTH)-1:0] WADDR,
   input  logic [LEN-1:0]           WMASK,
   input  logic [REPW-1:0]          WREP,
   input  logic [$clog2(DEPTH):0]   COUNT,
   input  logic                     B0,
   output logic [LEN-1:0]           MASK,
   output logic                     E,
   output logic                     RRST,
   output logic                     BUSY,
   output logic                     DONE,
   output logic [$clog2(DEPTH)-1:0] IDX
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   state_t          state_reg, state_next;
   logic [AW-1:0]   idx_reg, idx_next;
   logic [LEN-1:0]  mask_reg, mask_next;
   logic [REPW-1:0] rep_reg, rep_next;
   logic            b0_prev_reg, b0_prev_next;
   logic            done_reg, done_next;
   logic            adv;
   logic [LEN-1:0]  tab_mask;
   logic [REPW-1:0] tab_rep;
   logic [CW-1:0]   cnt_eff;
   logic            last_entry;
`ifdef SKIP_SCHED_LOOP_EN
   logic            live_reg, live_next;
   logic            adv_live;
`endif

   skip_masktab #(.LEN(LEN), .DEPTH(DEPTH), .REPW(REPW)) u_tab (
      .iCLK  (iCLK),
      .nRST  (nRST),
      .WE    (WE),
      .WADDR (WADDR),
      .WMASK (WMASK),
      .WREP  (WREP),
      .RADDR (idx_reg),
      .RMASK (tab_mask),
      .RREP  (tab_rep)
   );

   assign cnt_eff    = (COUNT > CW'(DEPTH)) ? CW'(DEPTH) : COUNT;
   assign last_entry = (({1'b0, idx_reg} + CW'(1)) >= cnt_eff);

   always_comb begin
      state_next   = state_reg;
      idx_next     = idx_reg;
      mask_next    = mask_reg;
      rep_next     = rep_reg;
      b0_prev_next = b0_prev_reg;
      done_next    = 1'b0;
      adv          = 1'b0;
`ifdef SKIP_SCHED_LOOP_EN
      live_next    = live_reg;
      adv_live     = live_reg;
`endif
      case (state_reg)
         ST_IDLE: begin
            b0_prev_next = 1'b0;
            if (START && !STOP) begin
               if (cnt_eff != '0) begin
                  state_next = ST_LOAD;
                  idx_next   = '0;
`ifdef SKIP_SCHED_LOOP_EN
                  live_next  = 1'b0;
`endif
               end else begin
                  done_next = 1'b1;
               end
            end
         end
         ST_LOAD: begin
            if (STOP) begin
               state_next = ST_IDLE;
            end else begin
               b0_prev_next = 1'b0;
               if (tab_rep != '0) begin
                  mask_next  = tab_mask;
                  rep_next   = tab_rep;
                  state_next = ST_RUN;
`ifdef SKIP_SCHED_LOOP_EN
                  live_next  = 1'b1;
`endif
               end else begin
                  adv = 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (STOP) begin
               state_next = ST_IDLE;
            end else begin
               b0_prev_next = B0;
               if (B0 && !b0_prev_reg) begin
                  rep_next = rep_reg - REPW'(1);
                  if (rep_reg == REPW'(1)) begin
                     adv = 1'b1;
`ifdef SKIP_SCHED_LOOP_EN
                     adv_live = 1'b1;
`endif
                  end
               end
            end
         end
         default: state_next = ST_IDLE;
      endcase

      if (adv) begin
         if (!last_entry) begin
            state_next = ST_LOAD;
            idx_next   = idx_reg + AW'(1);
         end else begin
`ifdef SKIP_SCHED_LOOP_EN
            // A pass where every entry was skipped would spin forever, so finish instead.
            if (adv_live) begin
               state_next = ST_LOAD;
               idx_next   = '0;
               live_next  = 1'b0;
            end else begin
               state_next = ST_IDLE;
               done_next  = 1'b1;
            end
`else
            state_next = ST_IDLE;
            done_next  = 1'b1;
`endif
         end
      end
   end

   always_ff @(posedge iCLK) begin
      if (!nRST) begin
         state_reg   <= ST_IDLE;
         idx_reg     <= '0;
         mask_reg    <= '0;
         rep_reg     <= '0;
         b0_prev_reg <= 1'b0;
         done_reg    <= 1'b0;
`ifdef SKIP_SCHED_LOOP_EN
         live_reg    <= 1'b0;
`endif
      end else begin
         state_reg   <= state_next;
         idx_reg     <= idx_next;
         mask_reg    <= mask_next;
         rep_reg     <= rep_next;
         b0_prev_reg <= b0_prev_next;
         done_reg    <= done_next;
`ifdef SKIP_SCHED_LOOP_EN
         live_reg    <= live_next;
`endif
      end
   end

   assign MASK = mask_reg;
   assign E    = (state_reg == ST_RUN);
   assign RRST = (state_reg != ST_RUN);
   assign BUSY = (state_reg != ST_IDLE);
   assign DONE = done_reg;
   assign IDX  = idx_reg;

endmodule

// File: tb/tb_skip_sched.sv
// Directed self-checking bench for skip_sched; loop-mode vectors run when SKIP_SCHED_LOOP_EN is defined.
module tb_skip_sched;

   localparam int LEN   = 16;
   localparam int DEPTH = 4;
   localparam int REPW  = 8;
   localparam int AW    = $clog2(DEPTH);

   logic            iCLK = 1'b0;
   logic            nRST;
   logic            START, STOP, WE, B0;
   logic [AW-1:0]   WADDR;
   logic [LEN-1:0]  WMASK;
   logic [REPW-1:0] WREP;
   logic [AW:0]     COUNT;
   logic [LEN-1:0]  MASK;
   logic            E, RRST, BUSY, DONE;
   logic [AW-1:0]   IDX;

   int n_checks = 0;
   int n_fail   = 0;

   skip_sched #(.LEN(LEN), .DEPTH(DEPTH), .REPW(REPW)) dut (
      .iCLK  (iCLK),
      .nRST  (nRST),
      .START (START),
      .STOP  (STOP),
      .WE    (WE),
      .WADDR (WADDR),
      .WMASK (WMASK),
      .WREP  (WREP),
      .COUNT (COUNT),
      .B0    (B0),
      .MASK  (MASK),
      .E     (E),
      .RRST  (RRST),
      .BUSY  (BUSY),
      .DONE  (DONE),
      .IDX   (IDX)
   );

   always #5 iCLK = ~iCLK;

   task automatic tick();
      @(posedge iCLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end else begin
         $display("ok   %s = %h", tag, obs);
      end
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [LEN-1:0] m, input logic [REPW-1:0] r);
      WE = 1'b1; WADDR = a; WMASK = m; WREP = r;
      tick();
      WE = 1'b0;
   endtask

   task automatic start_pulse();
      START = 1'b1;
      tick();
      START = 1'b0;
   endtask

   task automatic b0_edge();
      B0 = 1'b1;
      tick();
      B0 = 1'b0;
      tick();
   endtask

   initial begin
      nRST = 1'b0; START = 1'b0; STOP = 1'b0; WE = 1'b0; B0 = 1'b0;
      WADDR = '0; WMASK = '0; WREP = '0; COUNT = '0;
      tick(); tick();
      check("rst MASK", MASK, 0);
      check("rst E", E, 0);
      check("rst RRST", RRST, 1);
      check("rst BUSY", BUSY, 0);
      check("rst DONE", DONE, 0);
      check("rst IDX", IDX, 0);
      nRST = 1'b1;
      tick();

`ifndef SKIP_SCHED_LOOP_EN
      // Basic two-entry sequence
      wr(0, 16'h3445, 2);
      wr(1, 16'hFFFF, 1);
      COUNT = 2;
      start_pulse();
      check("seq load BUSY", BUSY, 1);
      check("seq load E", E, 0);
      check("seq load RRST", RRST, 1);
      tick();
      check("seq run0 MASK", MASK, 16'h3445);
      check("seq run0 E", E, 1);
      check("seq run0 RRST", RRST, 0);
      b0_edge();
      check("seq 1 edge MASK", MASK, 16'h3445);
      check("seq 1 edge IDX", IDX, 0);
      b0_edge();
      check("seq run1 MASK", MASK, 16'hFFFF);
      check("seq run1 IDX", IDX, 1);
      check("seq run1 E", E, 1);
      B0 = 1'b1;
      tick();
      check("seq end DONE", DONE, 1);
      check("seq end BUSY", BUSY, 0);
      check("seq end E", E, 0);
      check("seq end RRST", RRST, 1);
      check("seq end MASK", MASK, 16'hFFFF);
      B0 = 1'b0;
      tick();
      check("seq DONE width", DONE, 0);

      // Empty sequence and skipped entry
      COUNT = 0;
      start_pulse();
      check("cnt0 DONE", DONE, 1);
      check("cnt0 BUSY", BUSY, 0);
      tick();
      check("cnt0 DONE clr", DONE, 0);
      wr(1, 16'hFFFF, 0);
      wr(2, 16'h00F0, 1);
      COUNT = 3;
      start_pulse();
      tick();
      b0_edge();
      b0_edge();
      check("skip IDX", IDX, 2);
      check("skip BUSY", BUSY, 1);
      check("skip E", E, 0);
      check("skip MASK", MASK, 16'h3445);
      tick();
      check("skip run2 MASK", MASK, 16'h00F0);
      B0 = 1'b1;
      tick();
      check("skip end DONE", DONE, 1);
      B0 = 1'b0;
      tick();

      // STOP mid-run and START+STOP together
      COUNT = 2;
      start_pulse();
      tick();
      b0_edge();
      STOP = 1'b1;
      tick();
      STOP = 1'b0;
      check("stop BUSY", BUSY, 0);
      check("stop E", E, 0);
      check("stop DONE", DONE, 0);
      tick();
      check("stop DONE later", DONE, 0);
      START = 1'b1; STOP = 1'b1;
      tick();
      START = 1'b0; STOP = 1'b0;
      check("start+stop BUSY", BUSY, 0);
      check("start+stop DONE", DONE, 0);

      // Rewriting the running entry takes effect only on its next load
      COUNT = 1;
      start_pulse();
      tick();
      wr(0, 16'h0001, 5);
      check("wr-run MASK", MASK, 16'h3445);
      b0_edge();
      B0 = 1'b1;
      tick();
      check("wr-run end DONE", DONE, 1);
      check("wr-run end MASK", MASK, 16'h3445);
      B0 = 1'b0;
      tick();
      start_pulse();
      tick();
      check("wr-run reload MASK", MASK, 16'h0001);
      b0_edge();
      start_pulse();
      check("busy-start BUSY", BUSY, 1);
      check("busy-start E", E, 1);
      check("busy-start MASK", MASK, 16'h0001);
      STOP = 1'b1;
      tick();
      STOP = 1'b0;
      check("busy-start stop", BUSY, 0);

      // Reset mid-run overrides START and WE
      COUNT = 2;
      start_pulse();
      tick();
      b0_edge();
      nRST = 1'b0; START = 1'b1; WE = 1'b1; WADDR = 0; WMASK = 16'hABCD; WREP = 3;
      tick();
      check("mid-rst MASK", MASK, 0);
      check("mid-rst E", E, 0);
      check("mid-rst RRST", RRST, 1);
      check("mid-rst BUSY", BUSY, 0);
      check("mid-rst DONE", DONE, 0);
      check("mid-rst IDX", IDX, 0);
      nRST = 1'b1; START = 1'b0; WE = 1'b0;
      tick();
      check("post-rst DONE", DONE, 0);
      COUNT = 1;
      start_pulse();
      tick();
      check("cleared tab DONE", DONE, 1);
      check("cleared tab MASK", MASK, 0);
      check("cleared tab BUSY", BUSY, 0);

      // B0 held high counts once
      wr(0, 16'h1234, 2);
      start_pulse();
      tick();
      B0 = 1'b1;
      repeat (10) tick();
      check("b0 hold BUSY", BUSY, 1);
      check("b0 hold MASK", MASK, 16'h1234);
      B0 = 1'b0;
      tick();
      B0 = 1'b1;
      tick();
      check("b0 2nd edge DONE", DONE, 1);
      B0 = 1'b0;
      tick();
`endif

      // COUNT above DEPTH behaves as DEPTH
      wr(0, 16'h1234, 0);
      wr(1, 16'h0000, 0);
      wr(2, 16'h0000, 0);
      wr(3, 16'h0F0F, 1);
      COUNT = 7;
      start_pulse();
      repeat (4) tick();
      check("cnt7 IDX", IDX, 3);
      check("cnt7 MASK", MASK, 16'h0F0F);
      check("cnt7 E", E, 1);
      B0 = 1'b1;
      tick();
`ifdef SKIP_SCHED_LOOP_EN
      check("cnt7 wrap DONE", DONE, 0);
      check("cnt7 wrap IDX", IDX, 0);
      check("cnt7 wrap BUSY", BUSY, 1);
      B0 = 1'b0;
      STOP = 1'b1;
      tick();
      STOP = 1'b0;
`else
      check("cnt7 DONE", DONE, 1);
      check("cnt7 BUSY", BUSY, 0);
      B0 = 1'b0;
`endif
      tick();

`ifdef SKIP_SCHED_LOOP_EN
      // Looping: IDX alternates with no DONE
      wr(0, 16'hAAAA, 1);
      wr(1, 16'h5555, 1);
      COUNT = 2;
      start_pulse();
      tick();
      for (int k = 0; k < 6; k++) begin
         check($sformatf("loop idx %0d", k), IDX, k % 2);
         B0 = 1'b1;
         tick();
         check($sformatf("loop done %0d", k), DONE, 0);
         B0 = 1'b0;
         tick();
      end
      check("loop BUSY", BUSY, 1);
      STOP = 1'b1;
      tick();
      STOP = 1'b0;
      check("loop stop BUSY", BUSY, 0);

      // All-zero reps must terminate
      for (int a = 0; a < DEPTH; a++) wr(AW'(a), 16'h0000, 0);
      COUNT = DEPTH;
      start_pulse();
      begin
         bit found;
         found = 1'b0;
         for (int c = 0; c < 2 * DEPTH + 2 && !found; c++) begin
            if (DONE) found = 1'b1;
            else tick();
         end
         check("loop livelock DONE", found, 1);
      end
      check("loop livelock BUSY", BUSY, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/skip_sched.md
SKIP_SCHED -- requirements
Module: skip_sched

Interface
REQ-001 SHALL have parameter LEN, default 16, skipring mask width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, number of mask-table entries (power of two, >=2).
REQ-003 SHALL have parameter REPW, default 8, width of the per-entry revolution count.
REQ-004 SHALL have port iCLK  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port nRST  input  1  synchronous, active-low reset.
REQ-006 SHALL have ports START and STOP  input  1 each  single-cycle sequence start and abort requests.
REQ-007 SHALL have ports WE, WADDR, WMASK and WREP  input  1 / log2(DEPTH) / LEN / REPW  table write strobe, entry index, mask and revolution count.
REQ-008 SHALL have port COUNT  input  log2(DEPTH)+1  number of active entries (0..DEPTH); values above DEPTH are treated as DEPTH.
REQ-009 SHALL have port B0  input  1  ring bit-0 feedback from skipring, synchronous to iCLK.
REQ-010 SHALL have ports MASK, E and RRST  output  LEN / 1 / 1  drive skipring MASK, E and RST.
REQ-011 SHALL have ports BUSY, DONE and IDX  output  1 / 1 / log2(DEPTH)  sequence active, one-cycle completion pulse, and current entry.

Function
REQ-012 SHALL implement FSM states IDLE, LOAD and RUN.
REQ-013 IDLE SHALL drive E=0, RRST=1 and BUSY=0; START with effective COUNT>0 SHALL set IDX=0 and go to LOAD; START with COUNT=0 SHALL pulse DONE and stay in IDLE.
REQ-014 LOAD SHALL last exactly one cycle, register MASK<=tab[IDX].mask, load the revolution counter with tab[IDX].rep, hold RRST=1 and E=0, then go to RUN, or advance immediately when rep=0 (entry skipped).
REQ-015 RUN SHALL drive E=1 and RRST=0, and decrement the counter on each B0 rising edge (B0=1 while the registered previous B0=0); the edge detector SHALL be cleared in LOAD.
REQ-016 The edge that brings the counter to 0 SHALL advance: IDX+1<COUNT goes to LOAD with IDX+1; otherwise the sequence ends (REQ-025).
REQ-017 End of sequence without looping SHALL return to IDLE, pulse DONE for one cycle and keep MASK at the last loaded value.
REQ-018 STOP in LOAD or RUN SHALL go to IDLE on the next cycle without pulsing DONE; STOP and START together SHALL be treated as STOP.
REQ-019 START while BUSY=1 SHALL be ignored.
REQ-020 WE SHALL write {WMASK,WREP} to tab[WADDR] in one cycle in any state; MASK SHALL change only in LOAD, so writes to the running entry take effect on its next load.
REQ-021 BUSY SHALL be 1 exactly in LOAD and RUN.

Reset
REQ-022 nRST=0 at a rising edge SHALL force IDLE, MASK=0, E=0, RRST=1, BUSY=0, DONE=0, IDX=0, counter=0, edge register=0, and all table entries {0,0}, overriding START, STOP and WE in that cycle.
REQ-023 Reset asserted mid-sequence SHALL abort it with no DONE pulse.

Configuration
REQ-024 SHALL recognise macro SKIP_SCHED_LOOP_EN.
REQ-025 With SKIP_SCHED_LOOP_EN defined, end of sequence SHALL wrap IDX to 0 and go to LOAD, never pulsing DONE, until STOP or reset; if every active entry has rep=0, it SHALL return to IDLE with DONE to avoid a livelock. Without the macro, REQ-017 applies.

Structure
REQ-026 Package skip_pkg SHALL hold the default LEN, DEPTH and REPW constants, the FSM state enum and the table-entry struct {mask, rep}.
REQ-027 The mask table SHALL be a single sub-module skip_masktab (write port plus one asynchronous read port indexed by IDX); the FSM stays in skip_sched.

Verification
REQ-028 Program tab0={16'h3445,2}, tab1={16'hFFFF,1}, COUNT=2, START, then 3 B0 edges -> MASK=3445 for 2 edges, then FFFF for 1, then DONE for one cycle, BUSY=0, E=0, RRST=1.
REQ-029 COUNT=0 with START -> DONE the next cycle and BUSY stays 0; COUNT=3 with tab1.rep=0 -> entry 1 skipped and MASK never equals tab1.mask.
REQ-030 STOP during RUN after 1 of 2 edges -> IDLE the next cycle, E=0, no DONE; START and STOP in the same cycle -> stays IDLE.
REQ-031 Write tab0={16'h0001,5} during RUN on entry 0 -> MASK unchanged until the next LOAD of entry 0.
REQ-032 nRST low mid-RUN -> all REQ-022 values; the table reads back 0; B0 held high for 10 cycles counts as one edge only.
REQ-033 With SKIP_SCHED_LOOP_EN, COUNT=2 and reps {1,1}, 6 edges -> IDX sequence 0,1,0,1,0,1 with no DONE; all reps 0 -> DONE within 2*DEPTH+2 cycles.
